fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin packet arbiter sharing one asyncFIFO write port (wr_en/din/full/almost_full) among N requesters in the wr_clk domain.
- Grants one requester at a time and holds the grant until packet end (last beat) or a burst cap, so packets never interleave in the FIFO.
- Guarantees wr_en is never asserted while the FIFO reports full.
  - Required because the FIFO RAM writes on wr_en regardless of full.

Parameters:
- N, 4, number of requesters (2..16).
- WD, 256, data width; must match the FIFO's WD.
- MAXBURST, 16, maximum beats per grant before forced release (power of two, >=2).

Ports:
- wr_clk  input  1  clock; the same wr_clk that drives the FIFO write side.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  N  per-requester beat valid.
- in_last  input  N  per-requester last-beat-of-packet flag; qualified by in_valid.
- in_data  input  N*WD  per-requester data; requester i occupies bits [i*WD +: WD].
- in_ready  output  N  per-requester beat accept.
- fifo_full  input  1  FIFO full.
- fifo_almost_full  input  1  FIFO almost_full.
- fifo_wr_en  output  1  FIFO write enable.
- fifo_din  output  WD  FIFO write data.
- grant  output  N  registered one-hot owner; all zeros when idle.
- busy  output  1  high while in GRANT state.

Behaviour:
- States: IDLE, GRANT. Registers: state, grant, owner index, rr pointer (log2 N bits), beat counter (log2 MAXBURST bits).
- Reset (async, immediate): state=IDLE, grant=0, busy=0, rr pointer=0, beat counter=0.
  - Outputs during reset: in_ready=0, fifo_wr_en=0, fifo_din=0.
- IDLE:
  - in_ready=0 and fifo_wr_en=0.
  - If any in_valid is set and fifo_almost_full=0 and fifo_full=0:
    - Select the first set in_valid scanning from the rr pointer upward, wrapping modulo N.
    - Next cycle: state=GRANT, grant=onehot(selected), beat counter=0.
  - Otherwise stay in IDLE. A new packet is never started on almost_full or full.
- Arbitration latency: one cycle from in_valid to grant. First write occurs at the earliest one cycle after grant rises.
- GRANT, combinational outputs for owner k:
  - in_ready[k] = ~fifo_full; in_ready of all other requesters = 0.
  - fifo_wr_en = in_valid[k] & ~fifo_full.
  - fifo_din = in_data[k] when in GRANT; 0 in IDLE.
- Beat accepted (fifo_wr_en=1):
  - Beat counter increments and wraps at MAXBURST.
  - Release if in_last[k]=1 or beat counter==MAXBURST-1.
  - On release (next cycle): state=IDLE, grant=0, rr pointer=(k+1) mod N.
- Release always inserts exactly one IDLE cycle between grants. Minimum inter-packet gap is 1 cycle.
- Stalls:
  - in_valid[k]=0 while granted: grant holds with no timeout.
  - fifo_full=1: no beat accepted; grant, counter and state all hold.
- Burst-cap release mid-packet: owner k re-competes in round-robin and resumes its packet on a later grant. Data order within a requester is preserved.
- Simultaneous in_last and cap on the same beat: a single release. The counter is reset to 0 by the next grant.
- Requests from other requesters during GRANT are ignored. Their in_ready stays 0 and their data is not sampled.
- Reset asserted mid-packet: grant is dropped immediately. The partial packet remains in the FIFO, and the FIFO is reset by the same rst.

Test Plan:
- Single requester, N=4: req 2 sends a 3-beat packet with FIFO empty -> grant=4'b0100 one cycle after in_valid; fifo_wr_en high 3 consecutive cycles; fifo_din matches in_data[2]; grant=0 one cycle after beat 3; rr pointer=3.
- Fairness: all 4 requesters continuously valid with 1-beat packets -> grant sequence 0,1,2,3,0 with one IDLE cycle between grants; each requester gets exactly 1 beat per 8 cycles.
- Burst cap, MAXBURST=16: req 1 sends a 20-beat packet while req 3 is valid -> 16 beats from req 1, release, grant req 3, then req 1 resumes with 4 beats; FIFO contents are in that order.
- Full backpressure: fifo_full forced high for 5 cycles at beat 2 of a granted packet -> fifo_wr_en=0 and in_ready=0 for those 5 cycles; grant is held; beat 3 is written on the first cycle full drops; no extra FIFO write occurs.
- Almost-full gate: fifo_almost_full=1 with all requesters idle, then req 0 asserts in_valid -> grant stays 0 until almost_full falls, then grant=4'b0001 on the next cycle.
- Async reset mid-packet: rst pulsed between clock edges during beat 2 -> grant, busy, in_ready and fifo_wr_en go to 0 without waiting for a clock edge; after release the first grant goes to req 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet arbiter in front of one async FIFO write port.
// Holds a grant until packet end or burst cap; never writes while full.
module fifo_wr_arbiter #(
  parameter int N        = 4,
  parameter int WD       = 256,
  parameter int MAXBURST = 16
) (
  input  logic            wr_clk,
  input  logic            rst,
  input  logic [N-1:0]    in_valid,
  input  logic [N-1:0]    in_last,
  input  logic [N*WD-1:0] in_data,
  output logic [N-1:0]    in_ready,
  input  logic            fifo_full,
  input  logic            fifo_almost_full,
  output logic            fifo_wr_en,
  output logic [WD-1:0]   fifo_din,
  output logic [N-1:0]    grant,
  output logic            busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = $clog2(MAXBURST);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state, state_nx;
  logic [N-1:0]   grant_nx;
  logic [IW-1:0]  owner, owner_nx;
  logic [IW-1:0]  rr_ptr, rr_nx;
  logic [BW-1:0]  cnt, cnt_nx;

  logic           found;
  logic [IW-1:0]  sel;
  logic           beat;
  logic           rel;
  logic [IW-1:0]  owner_inc;
  int             t;

  // first valid requester at or after rr_ptr, wrapping modulo N
  always_comb begin
    found = 1'b0;
    sel   = '0;
    t     = 0;
    for (int i = 0; i < N; i++) begin
      t = int'(rr_ptr) + i;
      if (t >= N) t = t - N;
      if (!found && in_valid[t]) begin
        found = 1'b1;
        sel   = IW'(t);
      end
    end
  end

  assign owner_inc = (int'(owner) == N - 1) ? '0 : owner + 1'b1;

  assign beat = (state == GRANT) & in_valid[owner] & ~fifo_full;
  assign rel  = beat & (in_last[owner] | (cnt == BW'(MAXBURST - 1)));

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    owner_nx = owner;
    rr_nx    = rr_ptr;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (found && !fifo_almost_full && !fifo_full) begin
          state_nx = GRANT;
          grant_nx = N'(1) << sel;
          owner_nx = sel;
          cnt_nx   = '0;
        end
      end
      GRANT: begin
        if (beat) cnt_nx = cnt + 1'b1;
        if (rel) begin
          state_nx = IDLE;
          grant_nx = '0;
          rr_nx    = owner_inc;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      owner  <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nx;
      grant  <= grant_nx;
      owner  <= owner_nx;
      rr_ptr <= rr_nx;
      cnt    <= cnt_nx;
    end
  end

  // state is cleared asynchronously, so these drop the moment rst rises
  always_comb begin
    in_ready   = '0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    if (state == GRANT) begin
      in_ready   = grant & {N{~fifo_full}};
      fifo_wr_en = beat;
      fifo_din   = in_data[int'(owner)*WD +: WD];
    end
  end

  assign busy = (state == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: queued sources, FIFO write monitor.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int WD = 32;
  localparam int MB = 16;

  typedef struct packed {
    logic [WD-1:0] d;
    logic          l;
  } beat_t;

  logic            wr_clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    in_valid = '0;
  logic [N-1:0]    in_last = '0;
  logic [N*WD-1:0] in_data = '0;
  logic [N-1:0]    in_ready;
  logic            fifo_full = 1'b0;
  logic            fifo_almost_full = 1'b0;
  logic            fifo_wr_en;
  logic [WD-1:0]   fifo_din;
  logic [N-1:0]    grant;
  logic            busy;

  beat_t         srcq[N][$];
  logic [WD-1:0] expq[$];
  logic [N-1:0]  acc;
  int tests = 0;
  int fails = 0;

  fifo_wr_arbiter #(.N(N), .WD(WD), .MAXBURST(MB)) dut (
    .wr_clk(wr_clk), .rst(rst),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
    .in_ready(in_ready),
    .fifo_full(fifo_full), .fifo_almost_full(fifo_almost_full),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .grant(grant), .busy(busy)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [WD-1:0] mk(input int req, input int pid,
                                       input int b);
    return WD'((req << 24) | (pid << 8) | b);
  endfunction

  task automatic push_pkt(input int req, input int pid, input int n);
    for (int b = 0; b < n; b++)
      srcq[req].push_back('{d: mk(req, pid, b), l: (b == n - 1)});
  endtask

  task automatic exp_beats(input int req, input int pid,
                           input int b0, input int b1);
    for (int b = b0; b <= b1; b++) expq.push_back(mk(req, pid, b));
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      in_valid[i] = (srcq[i].size() != 0);
      in_last[i]  = in_valid[i] ? srcq[i][0].l : 1'b0;
      in_data[i*WD +: WD] = in_valid[i] ? srcq[i][0].d : '0;
    end
  endtask

  // one clock: sample accepts, pop accepted beats, present next beats
  task automatic step();
    @(negedge wr_clk);
    acc = in_ready & in_valid;
    @(posedge wr_clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i]) void'(srcq[i].pop_front());
    drive();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) srcq[i].delete();
    expq.delete();
    fifo_full = 1'b0;
    fifo_almost_full = 1'b0;
    drive();
    repeat (2) step();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_drain(input string name);
    int budget = 300;
    while (expq.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    check({name, "_drain_left"}, expq.size(), 0);
  endtask

  // FIFO-side scoreboard monitor
  always @(negedge wr_clk) begin
    if (!rst) begin
      if (fifo_wr_en && fifo_full) begin
        tests++;
        fails++;
        $display("FAIL wr_while_full: wr_en=1 full=1 at %0t", $time);
      end
      if (fifo_wr_en) begin
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_write: got din %h expected no write at %0t",
                   fifo_din, $time);
        end else begin
          check("fifo_din", fifo_din, expq.pop_front());
        end
      end
    end
  end

  initial begin
    drive();
    #2;
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_wr_en", 32'(fifo_wr_en), 0);
    check("rst_din", fifo_din, 0);
    check("rst_ready", 32'(in_ready), 0);
    do_reset();

    // single requester, 3-beat packet
    push_pkt(2, 1, 3);
    exp_beats(2, 1, 0, 2);
    drive();
    #1;
    check("t1_grant_idle", 32'(grant), 0);
    step();
    check("t1_grant", 32'(grant), 32'b0100);
    check("t1_busy", 32'(busy), 1);
    check("t1_ready", 32'(in_ready), 32'b0100);
    for (int b = 0; b < 3; b++) begin
      check("t1_wr_en", 32'(fifo_wr_en), 1);
      step();
    end
    check("t1_grant_rel", 32'(grant), 0);
    check("t1_wr_en_rel", 32'(fifo_wr_en), 0);
    // rr pointer now 3: req3 beats req0
    push_pkt(0, 2, 1);
    push_pkt(3, 2, 1);
    exp_beats(3, 2, 0, 0);
    exp_beats(0, 2, 0, 0);
    drive();
    step();
    check("t1_rr3", 32'(grant), 32'b1000);
    step();
    step();
    check("t1_rr0", 32'(grant), 32'b0001);
    wait_drain("t1");

    // fairness
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int q = 0; q < N; q++) begin
        push_pkt(q, 10 + r, 1);
        exp_beats(q, 10 + r, 0, 0);
      end
    drive();
    for (int j = 0; j < 16; j++) begin
      step();
      check("t2_grant", 32'(grant),
            (j % 2 == 0) ? (32'd1 << ((j / 2) % N)) : 32'd0);
    end
    wait_drain("t2");

    // burst cap
    do_reset();
    push_pkt(1, 20, 20);
    push_pkt(3, 21, 1);
    exp_beats(1, 20, 0, 15);
    exp_beats(3, 21, 0, 0);
    exp_beats(1, 20, 16, 19);
    drive();
    step();
    check("t3_grant1", 32'(grant), 32'b0010);
    repeat (16) step();
    check("t3_cap_rel", 32'(grant), 0);
    step();
    check("t3_grant3", 32'(grant), 32'b1000);
    step();
    step();
    check("t3_resume1", 32'(grant), 32'b0010);
    wait_drain("t3");

    // full backpressure
    do_reset();
    push_pkt(0, 30, 6);
    exp_beats(0, 30, 0, 5);
    drive();
    step();
    step();
    step();
    fifo_full = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      check("t4_wr_en_full", 32'(fifo_wr_en), 0);
      check("t4_ready_full", 32'(in_ready), 0);
      check("t4_grant_hold", 32'(grant), 32'b0001);
      step();
    end
    fifo_full = 1'b0;
    #1;
    check("t4_resume", 32'(fifo_wr_en), 1);
    check("t4_resume_din", fifo_din, mk(0, 30, 2));
    wait_drain("t4");

    // almost-full gate
    do_reset();
    fifo_almost_full = 1'b1;
    step();
    check("t5_idle", 32'(grant), 0);
    push_pkt(0, 40, 1);
    exp_beats(0, 40, 0, 0);
    drive();
    for (int c = 0; c < 3; c++) begin
      step();
      check("t5_af_block", 32'(grant), 0);
    end
    fifo_almost_full = 1'b0;
    #1;
    check("t5_pre", 32'(grant), 0);
    step();
    check("t5_grant", 32'(grant), 32'b0001);
    wait_drain("t5");

    // async reset mid-packet
    do_reset();
    push_pkt(2, 50, 5);
    exp_beats(2, 50, 0, 1);
    drive();
    step();
    step();
    step();
    check("t6_granted", 32'(grant), 32'b0100);
    #2;
    rst = 1'b1;
    #1;
    check("t6_grant", 32'(grant), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_ready", 32'(in_ready), 0);
    check("t6_wr_en", 32'(fifo_wr_en), 0);
    check("t6_drained_pre", expq.size(), 0);
    do_reset();
    push_pkt(3, 51, 1);
    push_pkt(0, 52, 1);
    exp_beats(0, 52, 0, 0);
    exp_beats(3, 51, 0, 0);
    drive();
    step();
    check("t6_first_req0", 32'(grant), 32'b0001);
    wait_drain("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
